// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per cycle,
// with a one-cycle path for divide-by-zero and signed overflow.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] result,
  output logic            done,
  output logic            busy,
  output logic            stall
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES    = '1;
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_next;

  logic [CW-1:0]     count;
  logic [2:0]        op;
  logic              neg_q;
  logic              neg_r;
  logic [XLEN-1:0]   b_mag;
  logic [2*XLEN-1:0] acc;

  logic              accept;
  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag_in, b_mag_in;
  logic              fast_zero, fast_ovf, fast;
  logic [XLEN-1:0]   fast_val;

  assign accept = start && (state == IDLE || state == DONE);
  assign stall  = accept || busy;

  // Operand decode at accept: magnitudes and sign flags are latched, raw operands are not.
  assign a_signed = funct3 inside {3'd1, 3'd2, 3'd4, 3'd6};
  assign b_signed = funct3 inside {3'd1, 3'd4, 3'd6};
  assign a_neg    = a_signed && op_a[XLEN-1];
  assign b_neg    = b_signed && op_b[XLEN-1];
  assign a_mag_in = a_neg ? -op_a : op_a;
  assign b_mag_in = b_neg ? -op_b : op_b;

  assign fast_zero = funct3[2] && (op_b == '0);
  assign fast_ovf  = (funct3 == 3'd4 || funct3 == 3'd6) && (op_a == MIN_INT) && (op_b == ONES);
  assign fast      = fast_zero || fast_ovf;

  always_comb begin
    fast_val = '0;
    if (fast_zero)
      fast_val = funct3[1] ? op_a : ONES;
    else if (funct3 == 3'd4)
      fast_val = MIN_INT;
  end

  // One iteration: acc holds {partial, multiplier} for multiply or {remainder, dividend} for divide.
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] acc_step;

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag} : '0);
    div_shift = acc[2*XLEN-1:XLEN-1];
    div_ge    = div_shift >= {1'b0, b_mag};
    div_diff  = div_shift[XLEN-1:0] - b_mag;
    if (op[2])
      acc_step = {(div_ge ? div_diff : div_shift[XLEN-1:0]), acc[XLEN-2:0], div_ge};
    else
      acc_step = {mul_sum, acc[XLEN-1:1]};
  end

  // Sign correction of the finished magnitude result.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo, rem, final_val;

  always_comb begin
    prod_fix  = neg_q ? -acc_step : acc_step;
    quo       = acc_step[XLEN-1:0];
    rem       = acc_step[2*XLEN-1:XLEN];
    final_val = '0;
    case (op)
      3'd0:                final_val = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    final_val = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:          final_val = neg_q ? -quo : quo;
      default:             final_val = neg_r ? -rem : rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start)
          state_next = fast ? DONE : BUSY;
        else
          state_next = IDLE;
      end
      BUSY: begin
        if (count == LAST)
          state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      count  <= '0;
      op     <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_mag  <= '0;
      acc    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op    <= funct3;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            b_mag <= b_mag_in;
            acc   <= {{XLEN{1'b0}}, a_mag_in};
            count <= '0;
            if (fast) begin
              result <= fast_val;
              done   <= 1'b1;
              busy   <= 1'b0;
            end else begin
              done <= 1'b0;
              busy <= 1'b1;
            end
          end else begin
            done <= 1'b0;
          end
        end
        BUSY: begin
          acc   <= acc_step;
          count <= count + 1'b1;
          if (count == LAST) begin
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= final_val;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
